// File: rtl/pc_sequencer_if.sv
// Fetch-side bus of the PC sequencer: redirect requests from ID/EX and the
// exception logic in one direction, and the fetch address and flushes in the other.
interface pc_sequencer_if;
   logic        stall;
   logic        jump_req;
   logic [31:0] jump_target;
   logic        branch_req;
   logic [31:0] branch_target;
   logic        exc_req;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_valid;
   logic        flush_if;
   logic        flush_id;
   logic        addr_err;
   logic [15:0] redirect_cnt;

   modport master (
      output stall, jump_req, jump_target, branch_req, branch_target, exc_req,
      input  pc, pc_plus4, fetch_valid, flush_if, flush_id, addr_err, redirect_cnt
   );

   modport slave (
      input  stall, jump_req, jump_target, branch_req, branch_target, exc_req,
      output pc, pc_plus4, fetch_valid, flush_if, flush_id, addr_err, redirect_cnt
   );
endinterface

// File: rtl/pc_sequencer.sv
// Owns the program counter: picks PC+4, jump, branch or exception vector,
// drives IF/ID flushes and keeps a saturating count of accepted redirects.
//  state | meaning
//  BOOT  | first cycle out of reset, no fetch, pc held
//  RUN   | fetching, redirect requests are accepted
//  DRAIN | one dead fetch cycle after an exception or misaligned target
module pc_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
   input logic           clk,
   input logic           reset,
   pc_sequencer_if.slave bus
);
   typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [31:0] r_pc;
   logic [31:0] w_next_pc;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_target;
   logic        r_addr_err;
   logic        w_next_err;
   logic [15:0] r_cnt;
   logic        w_exc_acc;
   logic        w_br_acc;
   logic        w_jmp_acc;
   logic        w_redirect;

   assign w_pc_plus4 = r_pc + 32'd4;

   always_comb begin
      w_next_state = r_state;
      w_next_pc    = r_pc;
      w_next_err   = 1'b0;
      w_exc_acc    = 1'b0;
      w_br_acc     = 1'b0;
      w_jmp_acc    = 1'b0;
      w_target     = bus.jump_target;
      case (r_state)
         BOOT:  w_next_state = RUN;
         DRAIN: w_next_state = RUN;
         RUN: begin
            // a stalled jump is simply not taken; ID holds and re-presents it
            w_exc_acc = bus.exc_req;
            w_br_acc  = !bus.exc_req && bus.branch_req;
            w_jmp_acc = !bus.exc_req && !bus.branch_req && bus.jump_req && !bus.stall;
            if (w_br_acc)
               w_target = bus.branch_target;
            if (w_exc_acc) begin
               w_next_pc    = EXC_VECTOR;
               w_next_state = DRAIN;
            end else if (w_br_acc || w_jmp_acc) begin
               if (w_target[1:0] != 2'b00) begin
                  w_next_pc    = EXC_VECTOR;
                  w_next_err   = 1'b1;
                  w_next_state = DRAIN;
               end else begin
                  w_next_pc = w_target;
               end
            end else if (!bus.stall) begin
               w_next_pc = w_pc_plus4;
            end
         end
         default: w_next_state = BOOT;
      endcase
   end

   assign w_redirect = w_exc_acc || w_br_acc || w_jmp_acc;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= BOOT;
         r_pc       <= RESET_PC;
         r_addr_err <= 1'b0;
         r_cnt      <= 16'h0000;
      end else begin
         r_state    <= w_next_state;
         r_pc       <= w_next_pc;
         r_addr_err <= w_next_err;
         if (w_redirect && (r_cnt != 16'hFFFF))
            r_cnt <= r_cnt + 16'd1;
      end
   end

   assign bus.pc           = r_pc;
   assign bus.pc_plus4     = w_pc_plus4;
   assign bus.fetch_valid  = (r_state == RUN);
   // a jump resolves in ID, so only exceptions and branches kill ID/EX
   assign bus.flush_if     = w_redirect;
   assign bus.flush_id     = w_exc_acc || w_br_acc;
   assign bus.addr_err     = r_addr_err;
   assign bus.redirect_cnt = r_cnt;
endmodule
